count_en_gen: RTL and testbench



---
 rtl/count_en_gen.sv | 176 +++++++++++++++++
 tb/tb_count_en_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_en_gen.sv
// count_en_gen: multi-channel programmable enable/strobe generator.
// Each channel emits a one-cycle en pulse every div sampled run-high edges
// (periodic mode) or once (one-shot mode, then parks in DONE until run drops).
// Optional feature macro: COUNT_EN_GEN_PHASE_ALIGN_EN adds a `sync` input that
// restarts every IDLE/COUNT channel so that running channels become phase aligned.
//
// Counter meaning: cnt holds the number of run-high samples taken in the current
// period, including the edge that wrote it. The terminal test is done on the value
// being written, so a pulse is launched on the N-th sampled edge and is visible in
// the following cycle. After a periodic terminal count cnt rests at div and the next
// sampled edge restarts it at 1, so cnt never exceeds div.
module count_en_gen #(
  parameter int CNT_W   = 16,
  parameter int SEL_W   = 2,
  parameter int DIV_RST = 50
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef COUNT_EN_GEN_PHASE_ALIGN_EN
  input  logic                  sync,
`endif
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic                  cfg_oneshot,
  input  logic [2**SEL_W-1:0]   run,
  output logic [2**SEL_W-1:0]   en,
  output logic [2**SEL_W-1:0]   done,
  output logic                  busy
);

  localparam int NCH = 2**SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Registered per-channel state
  state_t           state    [NCH];
  logic [CNT_W-1:0] cnt      [NCH];
  logic [CNT_W-1:0] div      [NCH];
  logic [NCH-1:0]   mode;

  // Next-state values
  state_t           state_nx [NCH];
  logic [CNT_W-1:0] cnt_nx   [NCH];
  logic [CNT_W-1:0] div_nx   [NCH];
  logic [NCH-1:0]   mode_nx;
  logic [NCH-1:0]   en_nx;
  logic [NCH-1:0]   done_nx;
  logic             busy_nx;

  // Decoded configuration
  logic [NCH-1:0]   cfg_hit;
  logic [CNT_W-1:0] cfg_div_eff;
  logic             sync_hit;

`ifdef COUNT_EN_GEN_PHASE_ALIGN_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // Value cnt takes on a sampled run-high edge: a fresh start from IDLE, or the
  // edge after a terminal count, begins a new period at 1.
  function automatic logic [CNT_W-1:0] step_count(
    input state_t           st,
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] d
  );
    if (st == ST_IDLE || c == d) begin
      return CNT_W'(1);
    end
    return c + CNT_W'(1);
  endfunction

  // Decode which channel a config write addresses; a zero divisor is stored as 1
  always_comb begin
    cfg_div_eff = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    for (int i = 0; i < NCH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_sel == SEL_W'(i));
    end
  end

  // Per-channel next-state logic: sync, then config write, then the FSM itself
  always_comb begin
    busy_nx = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      div_nx[i]   = div[i];
      mode_nx[i]  = mode[i];
      en_nx[i]    = 1'b0;
      done_nx[i]  = done[i];

      if (sync_hit) begin
        if (cfg_hit[i]) begin
          div_nx[i]  = cfg_div_eff;
          mode_nx[i] = cfg_oneshot;
        end
        if (state[i] != ST_DONE) begin
          state_nx[i] = ST_IDLE;
          cnt_nx[i]   = '0;
        end
      end else if (cfg_hit[i]) begin
        div_nx[i]   = cfg_div_eff;
        mode_nx[i]  = cfg_oneshot;
        cnt_nx[i]   = '0;
        state_nx[i] = ST_IDLE;
        done_nx[i]  = 1'b0;
      end else begin
        case (state[i])
          ST_IDLE, ST_COUNT: begin
            if (run[i]) begin
              cnt_nx[i]   = step_count(state[i], cnt[i], div[i]);
              state_nx[i] = ST_COUNT;
              if (cnt_nx[i] == div[i]) begin
                en_nx[i] = 1'b1;
                if (mode[i]) begin
                  state_nx[i] = ST_DONE;
                  cnt_nx[i]   = '0;
                  done_nx[i]  = 1'b1;
                end
              end
            end else if (state[i] == ST_IDLE) begin
              cnt_nx[i] = '0;
            end
          end
          ST_DONE: begin
            cnt_nx[i]  = '0;
            done_nx[i] = 1'b1;
            if (!run[i]) begin
              state_nx[i] = ST_IDLE;
              done_nx[i]  = 1'b0;
            end
          end
          default: begin
            state_nx[i] = ST_IDLE;
            cnt_nx[i]   = '0;
            done_nx[i]  = 1'b0;
          end
        endcase
      end

      busy_nx = busy_nx | (state_nx[i] == ST_COUNT);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
        div[i]   <= CNT_W'(DIV_RST);
      end
      mode <= '0;
      en   <= '0;
      done <= '0;
      busy <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
        div[i]   <= div_nx[i];
      end
      mode <= mode_nx;
      en   <= en_nx;
      done <= done_nx;
      busy <= busy_nx;
    end
  end

endmodule

// File: tb/tb_count_en_gen.sv
// Testbench for count_en_gen: vector table, directed corner sequences and
// randomized traffic, all checked against a sample-counting reference model.
module tb_count_en_gen;

  localparam int CNT_W   = 16;
  localparam int SEL_W   = 2;
  localparam int NCH     = 4;
  localparam int DIV_RST = 50;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             sync_in = 1'b0;
  logic             cfg_we = 1'b0;
  logic [SEL_W-1:0] cfg_sel = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_oneshot = 1'b0;
  logic [NCH-1:0]   run = '0;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   done;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  count_en_gen #(.CNT_W(CNT_W), .SEL_W(SEL_W), .DIV_RST(DIV_RST)) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef COUNT_EN_GEN_PHASE_ALIGN_EN
    .sync(sync_in),
`endif
    .cfg_we(cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_div(cfg_div),
    .cfg_oneshot(cfg_oneshot),
    .run(run),
    .en(en),
    .done(done),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: counts run-high samples since the channel started and
  // pulses whenever that count is a multiple of the divisor.
  int             m_samples [NCH];
  int             m_div     [NCH];
  bit             m_once    [NCH];
  bit             m_started [NCH];
  bit             m_done    [NCH];
  logic [NCH-1:0] m_en = '0;
  logic           m_busy = 1'b0;

  function automatic logic [NCH-1:0] model_done_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_done[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_samples[i] = 0;
      m_div[i]     = DIV_RST;
      m_once[i]    = 1'b0;
      m_started[i] = 1'b0;
      m_done[i]    = 1'b0;
    end
    m_en   = '0;
    m_busy = 1'b0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] en_n;
    bit hit;
    bit s;
    en_n = '0;
    s = sync_in;
`ifndef COUNT_EN_GEN_PHASE_ALIGN_EN
    s = 1'b0;
`endif
    if (RST) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      hit = cfg_we && (int'(cfg_sel) == i);
      if (s) begin
        if (hit) begin
          m_div[i]  = (cfg_div == 0) ? 1 : int'(cfg_div);
          m_once[i] = cfg_oneshot;
        end
        if (!m_done[i]) begin
          m_samples[i] = 0;
          m_started[i] = 1'b0;
        end
      end else if (hit) begin
        m_div[i]     = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_once[i]    = cfg_oneshot;
        m_samples[i] = 0;
        m_started[i] = 1'b0;
        m_done[i]    = 1'b0;
      end else if (m_done[i]) begin
        if (!run[i]) m_done[i] = 1'b0;
      end else if (run[i]) begin
        m_started[i] = 1'b1;
        m_samples[i]++;
        if (m_samples[i] % m_div[i] == 0) begin
          en_n[i] = 1'b1;
          if (m_once[i]) begin
            m_done[i]    = 1'b1;
            m_started[i] = 1'b0;
            m_samples[i] = 0;
          end
        end
      end
    end
    m_en   = en_n;
    m_busy = 1'b0;
    for (int i = 0; i < NCH; i++) m_busy |= (m_started[i] && !m_done[i]);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: update the model with the inputs sampled on it, then compare
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("model_en",   32'(en),   32'(m_en));
    check("model_done", 32'(done), 32'(model_done_vec()));
    check("model_busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic do_reset();
    cfg_we = 1'b0; run = '0; sync_in = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int dv, input bit os);
    cfg_we = 1'b1; cfg_sel = SEL_W'(sel); cfg_div = CNT_W'(dv); cfg_oneshot = os;
    step();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic           rst;
    logic           we;
    logic [1:0]     sel;
    logic [15:0]    dv;
    logic           os;
    logic [3:0]     rn;
    logic [3:0]     exp_en;
    logic [3:0]     exp_done;
    logic           exp_busy;
  } vec_t;

  vec_t vecs [17];

  initial begin : main
    int first;
    int pulses;
    int bad;
    int at;
    model_reset();

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd3, 16'd2, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h0, 4'h0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h0, 4'h0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 16'd1, 1'b1, 4'h8, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h8, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h0, 4'h8, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd3, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h0, 4'h0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};

    $display("[TB] vector table");
    for (int v = 0; v < 17; v++) begin
      RST = vecs[v].rst; cfg_we = vecs[v].we; cfg_sel = vecs[v].sel;
      cfg_div = vecs[v].dv; cfg_oneshot = vecs[v].os; run = vecs[v].rn;
      step();
      check($sformatf("vec%0d_en", v),   32'(en),   32'(vecs[v].exp_en));
      check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end
    RST = 1'b0; cfg_we = 1'b0; run = '0;

    $display("[TB] reset divisor of 50");
    do_reset();
    check("reset_en", 32'(en), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    run = 4'b0001;
    first = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (en[0] && first < 0) first = k;
    end
    check("first_pulse_div50", 32'(first), 32'd50);

    $display("[TB] periodic div 4");
    do_reset();
    cfg_write(1, 4, 1'b0);
    run = 4'b0010; pulses = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (en[1]) begin
        pulses++;
        if (k % 4 != 0) bad++;
      end
      if ((en & 4'b1101) != 0) bad++;
    end
    check("div4_pulse_count", 32'(pulses), 32'd5);
    check("div4_misplaced", 32'(bad), 32'd0);

    $display("[TB] one-shot div 3");
    do_reset();
    cfg_write(2, 3, 1'b1);
    run = 4'b0100; pulses = 0; at = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (en[2]) begin pulses++; at = k; end
    end
    check("oneshot_pulses", 32'(pulses), 32'd1);
    check("oneshot_edge", 32'(at), 32'd3);
    check("oneshot_done", 32'(done[2]), 32'd1);
    run = 4'b0000;
    step();
    check("oneshot_done_clear", 32'(done[2]), 32'd0);
    run = 4'b0100; first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (en[2] && first < 0) first = k;
    end
    check("oneshot_rearm_edge", 32'(first), 32'd3);

    $display("[TB] pause and resume");
    do_reset();
    cfg_write(3, 5, 1'b0);
    run = 4'b1000;
    for (int k = 0; k < 3; k++) step();
    run = 4'b0000; pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (en[3]) pulses++;
    end
    check("pause_no_pulse", 32'(pulses), 32'd0);
    check("pause_busy", 32'(busy), 32'd1);
    run = 4'b1000; first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (en[3] && first < 0) first = k;
    end
    check("resume_edge", 32'(first), 32'd2);

    $display("[TB] config write on terminal edge");
    do_reset();
    cfg_write(0, 4, 1'b0);
    run = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    cfg_write(0, 0, 1'b0);
    check("cfg_beats_terminal", 32'(en[0]), 32'd0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (en[0]) pulses++;
    end
    check("div0_continuous", 32'(pulses), 32'd5);

    $display("[TB] reset mid-count");
    do_reset();
    cfg_write(1, 4, 1'b0);
    run = 4'b0010;
    for (int k = 0; k < 3; k++) step();
    RST = 1'b1;
    step();
    check("midreset_en", 32'(en), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    RST = 1'b0; run = '0;
    step();

`ifdef COUNT_EN_GEN_PHASE_ALIGN_EN
    $display("[TB] phase alignment");
    do_reset();
    cfg_write(0, 4, 1'b0);
    cfg_write(1, 6, 1'b0);
    run = 4'b0001;
    step(); step();
    run = 4'b0011;
    for (int k = 0; k < 5; k++) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync_en_clear", 32'(en[1:0]), 32'h0);
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (en[0] && en[1]) pulses++;
    end
    check("sync_coincident", 32'(pulses), 32'd2);
    run = '0;
`endif

    $display("[TB] randomized traffic");
    do_reset();
    for (int k = 0; k < 600; k++) begin
      RST = ($urandom_range(0, 99) == 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_sel = SEL_W'($urandom_range(0, NCH - 1));
      cfg_div = CNT_W'($urandom_range(0, 7));
      cfg_oneshot = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) run = NCH'($urandom_range(0, 15));
`ifdef COUNT_EN_GEN_PHASE_ALIGN_EN
      sync_in = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
    RST = 1'b0; cfg_we = 1'b0; run = '0; sync_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
